// File: rtl/master_seq_pkg.sv
`default_nettype none
//============================================================================
// master_seq_pkg: shared encodings for the master transaction sequencer.
// Rev 1.0
//============================================================================
package master_seq_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ACQUIRE   = 3'd1;
  localparam logic [2:0] ST_EXEC      = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RELEASE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_ACQUIRE   = ST_ACQUIRE,
    S_EXEC      = ST_EXEC,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_RELEASE   = ST_RELEASE
  } seq_state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int RSP_RW_W  = 1;
  localparam int RSP_ERR_W = 1;

  // Command word layout is {rw, addr, data}.
  function automatic int cmd_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_cmd_fifo.sv
`default_nettype none
//============================================================================
// seq_cmd_fifo: synchronous first-word-fall-through FIFO with occupancy count.
// Rev 1.0
//============================================================================
module seq_cmd_fifo #(
  parameter int WIDTH      = 24,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_wdata,
  output logic                  o_full,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_rdata,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == C_DEPTH);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/master_txn_sequencer.sv
`default_nettype none
//============================================================================
// master_txn_sequencer: command FIFO plus FSM replaying commands through the
// bus master hold/execute/dvalid handshake. Rev 1.0
//============================================================================
module master_txn_sequencer
  import master_seq_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDRS_WIDTH     = 15,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int TIMEOUT_LEN     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_rw,
  input  logic [ADDRS_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]      cmd_wdata,
  output logic                       rsp_valid,
  output logic                       rsp_rw,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic                       m_hold,
  output logic                       m_execute,
  output logic                       m_RW,
  output logic [ADDRS_WIDTH-1:0]     m_address,
  output logic [DATA_WIDTH-1:0]      m_din,
  input  logic [DATA_WIDTH-1:0]      m_dout,
  input  logic                       m_dvalid,
  input  logic                       m_master_bsy,
  output logic                       seq_busy,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);

  localparam int CMD_W = cmd_width(ADDRS_WIDTH, DATA_WIDTH);
  localparam logic [TIMEOUT_LEN-1:0] C_WD_LIMIT = '1;

  logic [CMD_W-1:0]        w_fifo_wdata;
  logic [CMD_W-1:0]        w_fifo_rdata;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic                    w_head_rw;
  logic [ADDRS_WIDTH-1:0]  w_head_addr;
  logic [DATA_WIDTH-1:0]   w_head_data;

  seq_state_t              r_state;
  seq_state_t              w_next;
  logic                    w_pop;
  logic                    w_err;
  logic                    w_enter_release;
  logic                    w_wd_expired;
  logic                    w_dv_edge;

  logic                    r_hold;
  logic                    r_execute;
  logic                    r_rw;
  logic [ADDRS_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]   r_din;
  logic                    r_bsy_seen;
  logic                    r_dvalid_q;
  logic [TIMEOUT_LEN-1:0]  r_wd;
  logic                    r_rsp_valid;
  logic [RSP_RW_W-1:0]     r_rsp_rw;
  logic [RSP_ERR_W-1:0]    r_rsp_err;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;

  assign w_fifo_wdata = {cmd_rw, cmd_addr, cmd_wdata};
  assign {w_head_rw, w_head_addr, w_head_data} = w_fifo_rdata;

  seq_cmd_fifo #(
    .WIDTH      (CMD_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (cmd_valid),
    .i_wdata (w_fifo_wdata),
    .o_full  (w_fifo_full),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty),
    .o_count (fifo_count)
  );

  assign w_wd_expired    = (r_wd == C_WD_LIMIT);
  assign w_dv_edge       = m_dvalid && !r_dvalid_q;
  assign w_enter_release = (w_next == S_RELEASE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // A completion edge takes priority over a watchdog expiry in the same cycle.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop  = 1'b1;
          w_next = S_ACQUIRE;
        end
      end
      S_ACQUIRE: begin
        if (r_bsy_seen && !m_master_bsy) begin
          w_next = S_EXEC;
        end else if (w_wd_expired) begin
          w_next = S_RELEASE;
          w_err  = 1'b1;
        end
      end
      S_EXEC: w_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (w_dv_edge) begin
          w_next = S_RELEASE;
        end else if (w_wd_expired) begin
          w_next = S_RELEASE;
          w_err  = 1'b1;
        end
      end
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold      <= 1'b0;
      r_execute   <= 1'b0;
      r_rw        <= RW_READ;
      r_addr      <= '0;
      r_din       <= '0;
      r_bsy_seen  <= 1'b0;
      r_dvalid_q  <= 1'b0;
      r_wd        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rw    <= '0;
      r_rsp_err   <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_dvalid_q  <= m_dvalid;
      r_execute   <= (w_next == S_EXEC);
      r_rsp_valid <= w_enter_release;

      if (w_pop) begin
        r_rw       <= w_head_rw;
        r_addr     <= w_head_addr;
        r_din      <= w_head_data;
        r_hold     <= 1'b1;
        r_bsy_seen <= 1'b0;
        r_wd       <= '0;
      end else begin
        if (r_state == S_ACQUIRE && m_master_bsy) r_bsy_seen <= 1'b1;
        // EXEC is the only way into WAIT_DONE, so clear on the way through.
        if (r_state == S_EXEC) begin
          r_wd <= '0;
        end else if (r_state == S_ACQUIRE || r_state == S_WAIT_DONE) begin
          r_wd <= r_wd + 1'b1;
        end
      end

      if (w_enter_release) begin
        r_hold      <= 1'b0;
        r_rsp_rw    <= r_rw;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (r_rw == RW_WRITE || w_err) ? '0 : m_dout;
      end
    end
  end

  assign cmd_ready = !w_fifo_full;
  assign seq_busy  = (r_state != S_IDLE) || !w_fifo_empty;
  assign m_hold    = r_hold;
  assign m_execute = r_execute;
  assign m_RW      = r_rw;
  assign m_address = r_addr;
  assign m_din     = r_din;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rw    = r_rsp_rw;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_master_txn_sequencer.sv
`default_nettype none
//============================================================================
// tb_master_txn_sequencer: directed vectors plus handshake corner sequences.
// Rev 1.0
//============================================================================
module tb_master_txn_sequencer;

  localparam int DW = 8;
  localparam int AW = 15;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_rw;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          m_hold;
  logic          m_execute;
  logic          m_RW;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_din;
  logic [DW-1:0] m_dout;
  logic          m_dvalid;
  logic          m_master_bsy;
  logic          seq_busy;
  logic [2:0]    fifo_count;

  master_txn_sequencer #(
    .DATA_WIDTH      (DW),
    .ADDRS_WIDTH     (AW),
    .FIFO_DEPTH_LOG2 (2),
    .TIMEOUT_LEN     (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rw       (cmd_rw),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rw       (rsp_rw),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .m_hold       (m_hold),
    .m_execute    (m_execute),
    .m_RW         (m_RW),
    .m_address    (m_address),
    .m_din        (m_din),
    .m_dout       (m_dout),
    .m_dvalid     (m_dvalid),
    .m_master_bsy (m_master_bsy),
    .seq_busy     (seq_busy),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] sdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];
  int   total = 0;
  int   bad   = 0;
  int   rsp_cnt = 0;
  int   exp_rsp = 0;

  always @(negedge clk) if (rsp_valid === 1'b1) rsp_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_hold();
    int n = 0;
    while (m_hold !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("hold_rise", m_hold, 1);
  endtask

  task automatic drive_acquire();
    int n = 0;
    m_master_bsy = 1'b1;
    repeat (2) @(negedge clk);
    m_master_bsy = 1'b0;
    while (m_execute !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("exec_seen", m_execute, 1);
  endtask

  task automatic serve(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] sdata, input logic [DW-1:0] exp_rdata);
    wait_hold();
    drive_acquire();
    check("m_RW", m_RW, rw);
    check("m_address", m_address, a);
    check("m_din", m_din, d);
    @(negedge clk);
    check("exec_one_cycle", m_execute, 0);
    m_dout   = sdata;
    m_dvalid = 1'b1;
    @(negedge clk);
    m_dvalid = 1'b0;
    m_dout   = 8'h3C;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_rw", rsp_rw, rw);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", rsp_err, 0);
    check("hold_low_at_rsp", m_hold, 0);
    exp_rsp++;
    @(negedge clk);
    check("rsp_pulse_once", rsp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{rw: 1'b1, addr: 15'd21845, wdata: 8'd203, sdata: 8'h00, exp_rdata: 8'd0};
    vecs[1] = '{rw: 1'b0, addr: 15'd21845, wdata: 8'd0,   sdata: 8'd178, exp_rdata: 8'd178};
    vecs[2] = '{rw: 1'b1, addr: 15'h7FFF,  wdata: 8'hFF,  sdata: 8'h5A, exp_rdata: 8'd0};
    vecs[3] = '{rw: 1'b0, addr: 15'h0000,  wdata: 8'h77,  sdata: 8'h01, exp_rdata: 8'h01};
    vecs[4] = '{rw: 1'b0, addr: 15'h6001,  wdata: 8'h00,  sdata: 8'hFF, exp_rdata: 8'hFF};

    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    m_dout = '0; m_dvalid = 1'b0; m_master_bsy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_m_hold", m_hold, 0);
    check("rst_m_execute", m_execute, 0);
    check("rst_m_address", m_address, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_seq_busy", seq_busy, 0);

    // Single-command vectors, with exact hold latency from an idle sequencer.
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      check("hold_before_pop", m_hold, 0);
      check("count_after_push", fifo_count, 1);
      check("busy_after_push", seq_busy, 1);
      @(negedge clk);
      check("hold_latency", m_hold, 1);
      check("count_after_pop", fifo_count, 0);
      serve(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].sdata, vecs[i].exp_rdata);
    end

    // Back-to-back fill while the first command waits in ACQUIRE with bsy low.
    push(1'b1, 15'h1001, 8'h11);
    @(negedge clk);
    push(1'b0, 15'h2002, 8'h00);
    push(1'b1, 15'h3003, 8'h33);
    push(1'b0, 15'h4004, 8'h00);
    push(1'b1, 15'h5005, 8'h55);
    check("full_count", fifo_count, 4);
    check("full_ready", cmd_ready, 0);
    check("bsy_low_ignored", m_execute, 0);
    push(1'b0, 15'h6006, 8'h00);
    check("full_push_ignored", fifo_count, 4);
    serve(1'b1, 15'h1001, 8'h11, 8'h00, 8'h00);
    serve(1'b0, 15'h2002, 8'h00, 8'h22, 8'h22);
    serve(1'b1, 15'h3003, 8'h33, 8'h00, 8'h00);
    serve(1'b0, 15'h4004, 8'h00, 8'h44, 8'h44);
    serve(1'b1, 15'h5005, 8'h55, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("b2b_drained_count", fifo_count, 0);
    check("b2b_drained_busy", seq_busy, 0);

    // Watchdog in ACQUIRE: bsy never falls.
    push(1'b1, 15'h0ABC, 8'h9E);
    wait_hold();
    m_master_bsy = 1'b1;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("acq_timeout_cycles", (n >= 255 && n <= 258), 1);
    check("acq_timeout_rsp", rsp_valid, 1);
    check("acq_timeout_err", rsp_err, 1);
    check("acq_timeout_rdata", rsp_rdata, 0);
    check("acq_timeout_rw", rsp_rw, 1);
    check("acq_timeout_hold", m_hold, 0);
    exp_rsp++;
    m_master_bsy = 1'b0;
    @(negedge clk);
    push(1'b0, 15'h0123, 8'h00);
    serve(1'b0, 15'h0123, 8'h00, 8'h5A, 8'h5A);

    // Watchdog in WAIT_DONE: dvalid never arrives.
    push(1'b0, 15'h7FFE, 8'h00);
    wait_hold();
    drive_acquire();
    m_dout = 8'hEE;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_timeout_cycles", (n >= 256 && n <= 259), 1);
    check("wait_timeout_rsp", rsp_valid, 1);
    check("wait_timeout_err", rsp_err, 1);
    check("wait_timeout_rdata", rsp_rdata, 0);
    check("wait_timeout_hold", m_hold, 0);
    exp_rsp++;
    @(negedge clk);
    push(1'b1, 15'h2345, 8'hA5);
    serve(1'b1, 15'h2345, 8'hA5, 8'h00, 8'h00);

    // Reset in WAIT_DONE with a second command queued.
    push(1'b0, 15'h1357, 8'h00);
    push(1'b1, 15'h2468, 8'h42);
    wait_hold();
    drive_acquire();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_hold", m_hold, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_rsp", rsp_valid, 0);
    check("midrst_busy", seq_busy, 0);
    m_dout   = 8'h99;
    m_dvalid = 1'b1;
    @(negedge clk);
    m_dvalid = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_stays_idle", m_hold, 0);
    push(1'b1, 15'h0F0F, 8'hC3);
    serve(1'b1, 15'h0F0F, 8'hC3, 8'h00, 8'h00);

    repeat (3) @(negedge clk);
    check("rsp_count", rsp_cnt, exp_rsp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
